fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_lzc.sv | 18 +
 rtl/fp_normalizer.sv | 138 +++++++++++++
 tb/tb_fp_normalizer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and defaults for the floating-point normalizer slice.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FP_EXP_MIN = 1;
  localparam int FP_MANT_W  = 48;
  localparam int FP_EXP_W   = 10;

endpackage

// File: rtl/fp_lzc.sv
// Parameterized leading-zero counter; an all-zero input yields W.
module fp_lzc #(
  parameter int W     = 48,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     value,
  output logic [CNT_W-1:0] count
);

  // The highest set bit is visited last, so it determines the result.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Mantissa normalizer ahead of rounding: left-shifts out leading zeros, adjusting the exponent.
// Build option FP_NORM_LZC_EN replaces the 1-bit/cycle shifter with a single-cycle LZC shift.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_denorm,
  output logic              busy
);

  localparam logic [EXP_W-1:0] EXP_MIN = EXP_W'(FP_EXP_MIN);

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                zero_q, zero_d;
  logic                denorm_q, denorm_d;

`ifdef FP_NORM_LZC_EN
  localparam int LZC_W = $clog2(MANT_W + 1);
  localparam int SH_W  = (EXP_W > LZC_W) ? EXP_W : LZC_W;

  logic [LZC_W-1:0] lzc;
  logic [SH_W-1:0]  lzc_x, room, sh;

  fp_lzc #(.W(MANT_W), .CNT_W(LZC_W)) u_lzc (
    .value (mant_q),
    .count (lzc)
  );

  // The exponent may only drop to EXP_MIN, so the shift is capped by the room above it.
  assign lzc_x = SH_W'(lzc);
  assign room  = SH_W'(exp_q - EXP_MIN);
  assign sh    = (lzc_x < room) ? lzc_x : room;
`endif

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = in_exp;
          mant_d   = in_mant;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          state_d = DONE;
        end else if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q <= EXP_MIN) begin
          denorm_d = 1'b1;
          exp_d    = '0;
          state_d  = DONE;
        end else begin
`ifdef FP_NORM_LZC_EN
          mant_d  = mant_q << sh;
          state_d = DONE;
          if (sh < lzc_x) begin
            denorm_d = 1'b1;
            exp_d    = '0;
          end else begin
            exp_d = exp_q - EXP_W'(sh);
          end
`else
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
`endif
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_sign   = sign_q;
  assign out_exp    = exp_q;
  assign out_mant   = mant_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer (default iterative build): directed vectors plus random operands.
module tb_fp_normalizer;

  localparam int MW = 48;
  localparam int EW = 10;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;
  logic          out_zero;
  logic          out_denorm;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fp_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_mant   (out_mant),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: shift count is the leading-zero count limited by the exponent headroom above 1.
  task automatic model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                       output logic [MW-1:0] em, output logic [EW-1:0] ee,
                       output logic ez, output logic ed, output int lat);
    int lz, room, sh;
    ez = 1'b0; ed = 1'b0; lat = 1;
    if (m == '0) begin
      em = '0; ee = '0; ez = 1'b1;
    end else begin
      lz = 0;
      while (m[MW-1-lz] == 1'b0) lz++;
      room = (int'(e) > 1) ? int'(e) - 1 : 0;
      sh   = (lz < room) ? lz : room;
      em   = m << sh;
      ed   = (lz > sh);
      ee   = ed ? '0 : EW'(int'(e) - sh);
      lat  = sh + 1;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [EW-1:0] e,
                        input logic [MW-1:0] m, input int hold);
    logic [MW-1:0] em;
    logic [EW-1:0] ee;
    logic ez, ed;
    int lat, cyc;
    model(m, e, em, ee, ez, ed, lat);

    @(negedge clk);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);

    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".mant"}, 64'(out_mant), 64'(em));
    check({tag, ".exp"}, 64'(out_exp), 64'(ee));
    check({tag, ".sign"}, 64'(out_sign), 64'(s));
    check({tag, ".zero"}, 64'(out_zero), 64'(ez));
    check({tag, ".denorm"}, 64'(out_denorm), 64'(ed));

    // A competing operand offered during backpressure must be ignored.
    in_valid = 1'b1; in_sign = ~s; in_exp = ~e; in_mant = ~m;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_out"}, {out_sign, out_zero, out_denorm, out_exp[EW-1:0], out_mant[50-EW:0]},
            {s, ez, ed, ee, em[50-EW:0]});
      check({tag, ".hold_mant"}, 64'(out_mant), 64'(em));
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".after_hs_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".after_hs_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    logic [MW-1:0] rm;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.out_mant", 64'(out_mant), 64'd0);
    check("reset.out_flags", {out_exp, out_sign, out_zero, out_denorm}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("normal",   1'b0, 10'd130, 48'h8000_0000_0000, 0);
    run_op("lz3_bp",   1'b0, 10'd130, 48'h1000_0000_0001, 5);
    run_op("denorm",   1'b1, 10'd3,   48'h0800_0000_0000, 1);
    run_op("zero",     1'b1, 10'd200, 48'h0000_0000_0000, 0);
    run_op("exp1",     1'b0, 10'd1,   48'h0000_0000_00F0, 0);
    run_op("exp0_msb", 1'b1, 10'd0,   48'hC000_0000_0000, 0);
    run_op("lz_eq",    1'b0, 10'd5,   48'h0800_0000_0000, 2);
    run_op("lsb_only", 1'b0, 10'd300, 48'h0000_0000_0001, 0);

    for (int n = 0; n < 24; n++) begin
      rm = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
      if ($urandom_range(0, 9) == 0) rm = '0;
      run_op($sformatf("rand%0d", n), 1'($urandom), EW'($urandom_range(0, 300)), rm, $urandom_range(0, 3));
    end

    // Reset in the middle of a long shift: the operand must vanish.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 10'd130; in_mant = 48'h0000_0100_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 64'(out_valid), 64'd0);
    check("midreset.in_ready", 64'(in_ready), 64'd1);
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.out_mant", 64'(out_mant), 64'd0);
    check("midreset.out_flags", {out_exp, out_sign, out_zero, out_denorm}, 64'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("midreset.no_output", 64'(seen), 64'd0);
    check("midreset.idle", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
